// File: rtl/grant_sched4.sv
// grant_sched4: four-way round-robin grant scheduler with
// break-before-make gap and bounded hold time under contention.

module decode24 (
    input  logic       en_i,
    input  logic       a_i,
    input  logic       b_i,
    output logic [3:0] y_o
);

    // One-hot decode of {A,B}; all zero when disabled.
    always_comb begin
        y_o = 4'b0000;
        if (en_i) y_o[{a_i, b_i}] = 1'b1;
    end

endmodule

module grant_sched4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       grant_en,
    output logic [1:0] grant_idx,
    output logic [3:0] gnt,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [7:0] HOLD_LAST =
        (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

    state_e     state_q, state_d;
    logic       en_q, en_d;
    logic [1:0] idx_q, idx_d;
    logic       pre_q, pre_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] win;
    logic       others;
    logic       expire;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        win = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
        end
    end

    assign others = |(req & ~(4'b0001 << idx_q));
    // Comparing with >= keeps the hold bounded even when a
    // competitor shows up after the owner has run long alone.
    assign expire = (HOLD_MAX != 0) && (hold_q >= HOLD_LAST)
                    && others;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        idx_d   = idx_q;
        pre_d   = 1'b0;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE, GAP: begin
                en_d    = 1'b0;
                state_d = IDLE;
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = win;
                    en_d    = 1'b1;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                if (!req[idx_q] || expire) begin
                    state_d = GAP;
                    en_d    = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                    pre_d   = req[idx_q];
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            idx_q   <= 2'd0;
            pre_q   <= 1'b0;
            ptr_q   <= 2'd0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant_en  = en_q;
    assign grant_idx = idx_q;
    assign preempt   = pre_q;

    decode24 u_dec (
        .en_i (en_q),
        .a_i  (idx_q[1]),
        .b_i  (idx_q[0]),
        .y_o  (gnt)
    );

endmodule
